// File: rtl/gcd_engine.sv
// gcd_engine: subtractive GCD unit with an integrated controller.
//
// Operands are taken on a valid/ready input channel. The result is returned on a
// valid/ready output channel. Only one operation is in flight at a time.
// A zero operand skips the subtraction loop: the result is a_in | b_in.
//
// Parameters:
//   WIDTH      operand/result width in bits (>= 2)
// Ports:
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand pair valid
//   in_ready   engine accepts operands (idle only)
//   a_in/b_in  unsigned operands
//   out_valid  result valid (done only)
//   out_ready  consumer accepts result
//   gcd_out    GCD result, held while out_valid is high
//   zero_op    at least one captured operand was zero
//   iter_cnt   saturating subtraction count (present only with GCD_ITER_CNT_EN)
//
// Build option: define GCD_ITER_CNT_EN to add the iter_cnt port and its counter.

module gcd_engine #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] gcd_out,
    output logic             zero_op
`ifdef GCD_ITER_CNT_EN
    ,
    output logic [WIDTH-1:0] iter_cnt
`endif
);

    typedef enum logic [1:0] {
        StIdle,
        StCalc,
        StDone
    } state_e;

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] gcd_q;
    logic             zero_op_q;
    logic             in_ready_q;
    logic             out_valid_q;
`ifdef GCD_ITER_CNT_EN
    logic [WIDTH-1:0] iter_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            gcd_q       <= '0;
            zero_op_q   <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef GCD_ITER_CNT_EN
            iter_q      <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q        <= a_in;
                        b_q        <= b_in;
                        zero_op_q  <= (a_in == '0) || (b_in == '0);
                        in_ready_q <= 1'b0;
`ifdef GCD_ITER_CNT_EN
                        iter_q     <= '0;
`endif
                        if ((a_in == '0) || (b_in == '0)) begin
                            // gcd(x,0) = x, and gcd(0,0) = 0
                            gcd_q       <= a_in | b_in;
                            out_valid_q <= 1'b1;
                            state_q     <= StDone;
                        end else begin
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    if (a_q == b_q) begin
                        gcd_q       <= a_q;
                        out_valid_q <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        // Smaller is always subtracted from larger, so no wrap.
                        if (a_q > b_q) begin
                            a_q <= a_q - b_q;
                        end else begin
                            b_q <= b_q - a_q;
                        end
`ifdef GCD_ITER_CNT_EN
                        if (iter_q != {WIDTH{1'b1}}) begin
                            iter_q <= iter_q + WIDTH'(1);
                        end
`endif
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= StIdle;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign gcd_out   = gcd_q;
    assign zero_op   = zero_op_q;
`ifdef GCD_ITER_CNT_EN
    assign iter_cnt  = iter_q;
`endif

endmodule

// File: tb/tb_gcd_engine.sv
// Testbench for gcd_engine: an 8-bit and a 16-bit instance share the clock and reset.
// Directed table vectors, hand-written reset/backpressure sequences and random pairs
// are checked against a Euclid-based reference model.

module tb_gcd_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [31:0] a_drv;
    logic [31:0] b_drv;
    logic        sel;       // 0: 8-bit instance, 1: 16-bit instance

    logic        ir8, ov8, z8;
    logic [7:0]  g8;
    logic        ir16, ov16, z16;
    logic [15:0] g16;
`ifdef GCD_ITER_CNT_EN
    logic [7:0]  it8;
    logic [15:0] it16;
`endif

    gcd_engine #(.WIDTH(8)) u_dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid & ~sel),
        .in_ready  (ir8),
        .a_in      (a_drv[7:0]),
        .b_in      (b_drv[7:0]),
        .out_valid (ov8),
        .out_ready (out_ready),
        .gcd_out   (g8),
        .zero_op   (z8)
`ifdef GCD_ITER_CNT_EN
        ,
        .iter_cnt  (it8)
`endif
    );

    gcd_engine #(.WIDTH(16)) u_dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid & sel),
        .in_ready  (ir16),
        .a_in      (a_drv[15:0]),
        .b_in      (b_drv[15:0]),
        .out_valid (ov16),
        .out_ready (out_ready),
        .gcd_out   (g16),
        .zero_op   (z16)
`ifdef GCD_ITER_CNT_EN
        ,
        .iter_cnt  (it16)
`endif
    );

    logic        ir, ov, zo;
    logic [31:0] gv;
    logic [31:0] itv;
    assign ir = sel ? ir16 : ir8;
    assign ov = sel ? ov16 : ov8;
    assign zo = sel ? z16  : z8;
    assign gv = sel ? {16'd0, g16} : {24'd0, g8};
`ifdef GCD_ITER_CNT_EN
    assign itv = sel ? {16'd0, it16} : {24'd0, it8};
`else
    assign itv = 32'd0;
`endif

    int n_vec = 0;
    int n_mis = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: Euclid by division. The subtractive loop performs sum(quotients)-1
    // subtractions and needs one more edge for the final equal compare.
    task automatic ref_gcd(input int unsigned a, input int unsigned b, input int w,
                           output int unsigned g, output bit z, output int unsigned it,
                           output int lat);
        int unsigned x, y, t, sum, maxv;
        maxv = (w >= 32) ? 32'hffff_ffff : ((32'd1 << w) - 1);
        if (a == 0 || b == 0) begin
            g = a | b; z = 1'b1; it = 0; lat = 0;
        end else begin
            x = a; y = b; sum = 0;
            while (y != 0) begin
                sum += x / y;
                t = x % y; x = y; y = t;
            end
            g = x; z = 1'b0; lat = int'(sum);
            it = (sum - 1 > maxv) ? maxv : sum - 1;
        end
    endtask

    // Issue one operation, wait for the result, hold it for `hold` cycles, then accept.
    task automatic run_op(input bit s, input int unsigned a, input int unsigned b,
                          input int hold, input int unsigned eg, input bit ez,
                          input int unsigned eit, input int elat, input string tag);
        int lat;
        int budget;
        sel = s;
        out_ready = 1'b0;
        #1;
        chk({tag, ".in_ready"}, {31'd0, ir}, 32'd1);
        a_drv = a; b_drv = b; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        budget = s ? 70000 : 300;
        while (!ov && lat < budget) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, ".latency"}, lat, elat);
        chk({tag, ".gcd"}, gv, eg);
        chk({tag, ".zero_op"}, {31'd0, zo}, {31'd0, ez});
`ifdef GCD_ITER_CNT_EN
        chk({tag, ".iter_cnt"}, itv, eit);
`else
        if (eit != 0) begin end
`endif
        for (int i = 0; i < hold; i++) begin
            in_valid = ~i[0];
            a_drv = $urandom; b_drv = $urandom;
            @(negedge clk);
            chk({tag, ".hold_valid"}, {31'd0, ov}, 32'd1);
            chk({tag, ".hold_gcd"}, gv, eg);
            chk({tag, ".hold_in_ready"}, {31'd0, ir}, 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ".accept_valid"}, {31'd0, ov}, 32'd0);
        chk({tag, ".accept_ready"}, {31'd0, ir}, 32'd1);
    endtask

    typedef struct {
        bit          s;
        int unsigned a;
        int unsigned b;
        int          hold;
        int unsigned g;
        bit          z;
        int unsigned it;
        int          lat;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int unsigned g, it, ra, rb;
        bit          z;
        int          lat;

        tbl[0] = '{1'b0, 12,    18,  0, 6,   1'b0, 2,   3};
        tbl[1] = '{1'b0, 0,     5,   0, 5,   1'b1, 0,   0};
        tbl[2] = '{1'b0, 0,     0,   0, 0,   1'b1, 0,   0};
        tbl[3] = '{1'b0, 255,   1,   0, 1,   1'b0, 254, 255};
        tbl[4] = '{1'b0, 37,    37,  0, 37,  1'b0, 0,   1};
        tbl[5] = '{1'b0, 48,    36,  5, 12,  1'b0, 3,   4};
        tbl[6] = '{1'b1, 65535, 255, 0, 255, 1'b0, 256, 257};
        tbl[7] = '{1'b0, 7,     0,   2, 7,   1'b1, 0,   0};

        sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a_drv = '0; b_drv = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset.out_valid", {31'd0, ov}, 32'd0);
        chk("reset.gcd", gv, 32'd0);
        chk("reset.zero_op", {31'd0, zo}, 32'd0);
        chk("reset.iter", itv, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset.in_ready", {31'd0, ir}, 32'd1);

        foreach (tbl[i]) begin
            run_op(tbl[i].s, tbl[i].a, tbl[i].b, tbl[i].hold, tbl[i].g, tbl[i].z,
                   tbl[i].it, tbl[i].lat, $sformatf("vec%0d", i));
        end

        // Reset in the middle of a long computation; gcd_out still holds 5 beforehand.
        run_op(1'b0, 0, 5, 0, 5, 1'b1, 0, 0, "pre_rst");
        sel = 1'b0; a_drv = 255; b_drv = 1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_calc.out_valid", {31'd0, ov}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst.out_valid", {31'd0, ov}, 32'd0);
        chk("mid_rst.gcd", gv, 32'd0);
        chk("mid_rst.zero_op", {31'd0, zo}, 32'd0);
        chk("mid_rst.iter", itv, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(1'b0, 9, 6, 0, 3, 1'b0, 2, 3, "post_rst");

        // Back-to-back random pairs, 8-bit (zeros allowed) then 16-bit.
        for (int i = 0; i < 20; i++) begin
            ra = $urandom_range(0, 255);
            rb = $urandom_range(0, 255);
            ref_gcd(ra, rb, 8, g, z, it, lat);
            run_op(1'b0, ra, rb, 0, g, z, it, lat, $sformatf("rnd8_%0d_%0d", ra, rb));
        end
        for (int i = 0; i < 20; i++) begin
            ra = $urandom_range(256, 65535);
            rb = $urandom_range(256, 65535);
            ref_gcd(ra, rb, 16, g, z, it, lat);
            run_op(1'b1, ra, rb, 0, g, z, it, lat, $sformatf("rnd16_%0d_%0d", ra, rb));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
